// File: rtl/qbus_dma_arbiter.sv
// Q-bus DMA arbiter: synchronises per-device DMR, holds the core off the bus and grants one DMGO.
// Define CONFIG_QBUS_DMA_RR_EN for round-robin arbitration; otherwise index 0 has fixed priority.
module qbus_dma_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned GNT_TO = 255
) (
    input  logic            pin_clk,
    input  logic            pin_rst_n,
    input  logic [NREQ-1:0] pin_dmr_n,
    input  logic            pin_sack_n,
    input  logic            pin_sync_n,
    input  logic            pin_rply_n,
    output logic [NREQ-1:0] pin_dmgo_n,
    output logic            cpu_hold,
    output logic [2:0]      gnt_idx,
    output logic            gnt_tout
);

    typedef enum logic [2:0] {StIdle, StHold, StGrant, StMaster, StRelease} state_e;

    state_e          state;
    logic [7:0]      timer;
    logic [NREQ-1:0] dmr_meta, dmr_sync;
    logic            sack_meta, sack_sync;
    logic [NREQ-1:0] req;
    logic            sack;
    logic            bus_idle;
    logic [2:0]      win_idx;
    logic [NREQ-1:0] win_onehot;

    // DMR and SACK come from other clock domains; reset to the inactive (high) level.
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            dmr_meta  <= '1;
            dmr_sync  <= '1;
            sack_meta <= 1'b1;
            sack_sync <= 1'b1;
        end else begin
            dmr_meta  <= pin_dmr_n;
            dmr_sync  <= dmr_meta;
            sack_meta <= pin_sack_n;
            sack_sync <= sack_meta;
        end
    end

    assign req      = ~dmr_sync;
    assign sack     = ~sack_sync;
    assign bus_idle = pin_sync_n & pin_rply_n & ~sack;

`ifdef CONFIG_QBUS_DMA_RR_EN
    logic [2:0]        rr_ptr;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [2:0]        rot_off;
    logic [3:0]        cand;

    // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req} >> rr_ptr;
        req_rot = req_dbl[NREQ-1:0];
        rot_off = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) rot_off = i[2:0];
        end
        cand = {1'b0, rr_ptr} + {1'b0, rot_off};
        if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
        win_idx = cand[2:0];
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) win_idx = i[2:0];
        end
    end
`endif

    assign win_onehot = NREQ'(1) << win_idx;

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state      <= StIdle;
            pin_dmgo_n <= '1;
            cpu_hold   <= 1'b0;
            gnt_idx    <= '0;
            gnt_tout   <= 1'b0;
            timer      <= '0;
`ifdef CONFIG_QBUS_DMA_RR_EN
            rr_ptr     <= '0;
`endif
        end else begin
            gnt_tout <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        state    <= StHold;
                        cpu_hold <= 1'b1;
                    end
                end
                StHold: begin
                    if (~|req) begin
                        state <= StRelease;
                    end else if (bus_idle) begin
                        state      <= StGrant;
                        gnt_idx    <= win_idx;
                        timer      <= '0;
                        pin_dmgo_n <= ~win_onehot;
                    end
                end
                StGrant: begin
                    timer <= timer + 8'd1;
                    if (sack) begin
                        state      <= StMaster;
                        pin_dmgo_n <= '1;
`ifdef CONFIG_QBUS_DMA_RR_EN
                        rr_ptr <= ({1'b0, gnt_idx} + 4'd1 >= 4'(NREQ)) ? 3'd0 : gnt_idx + 3'd1;
`endif
                    end else if (~|(req & ~pin_dmgo_n)) begin
                        // The granted device dropped its request before acknowledging.
                        state      <= StRelease;
                        pin_dmgo_n <= '1;
                    end else if (timer == 8'(GNT_TO - 1)) begin
                        state      <= StRelease;
                        pin_dmgo_n <= '1;
                        gnt_tout   <= 1'b1;
                    end
                end
                StMaster: begin
                    if (!sack) state <= StRelease;
                end
                StRelease: begin
                    state    <= StIdle;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state      <= StIdle;
                    pin_dmgo_n <= '1;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Bench for qbus_dma_arbiter: cycle model of the arbitration rules plus directed literal checks.
module tb_qbus_dma_arbiter;

    localparam int NREQ   = 4;
    localparam int GNT_TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dmr_n;
    logic       sack_n, sync_n, rply_n;
    logic [3:0] dmgo_n;
    logic       cpu_hold;
    logic [2:0] gnt_idx;
    logic       gnt_tout;

    int total = 0;
    int bad   = 0;

    qbus_dma_arbiter #(.NREQ(NREQ), .GNT_TO(GNT_TO)) dut (
        .pin_clk    (clk),
        .pin_rst_n  (rst_n),
        .pin_dmr_n  (dmr_n),
        .pin_sack_n (sack_n),
        .pin_sync_n (sync_n),
        .pin_rply_n (rply_n),
        .pin_dmgo_n (dmgo_n),
        .cpu_hold   (cpu_hold),
        .gnt_idx    (gnt_idx),
        .gnt_tout   (gnt_tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 hold, 2 grant, 3 master, 4 release.
    logic [3:0] h1, h2;
    logic       s1, s2;
    int         ph, midx, mcnt, mptr;
    logic       mtout;
    logic [3:0] mreq;
    logic       msack, midle;

    assign mreq  = ~h2;
    assign msack = ~s2;
    assign midle = sync_n & rply_n & ~msack;

    function automatic int pick(input logic [3:0] r, input int p);
        int c;
        for (int k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (((r >> c) & 4'd1) != 4'd0) return c;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '1; h2 <= '1; s1 <= 1'b1; s2 <= 1'b1;
            ph <= 0; midx <= 0; mcnt <= 0; mptr <= 0; mtout <= 1'b0;
        end else begin
            h1 <= dmr_n; h2 <= h1; s1 <= sack_n; s2 <= s1;
            mtout <= 1'b0;
            case (ph)
                0: if (mreq != 4'd0) ph <= 1;
                1: begin
                    if (mreq == 4'd0) ph <= 4;
                    else if (midle) begin
                        midx <= pick(mreq, mptr);
                        mcnt <= 0;
                        ph   <= 2;
                    end
                end
                2: begin
                    if (msack) begin
                        ph <= 3;
`ifdef CONFIG_QBUS_DMA_RR_EN
                        mptr <= (midx + 1) % NREQ;
`endif
                    end else if (((mreq >> midx) & 4'd1) == 4'd0) ph <= 4;
                    else if (mcnt + 1 == GNT_TO) begin
                        mtout <= 1'b1;
                        ph    <= 4;
                    end else mcnt <= mcnt + 1;
                end
                3: if (!msack) ph <= 4;
                default: ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        automatic logic [3:0] exp_dmgo = (ph == 2) ? ~(4'b0001 << midx) : 4'hF;
        chk("model_dmgo", 32'(dmgo_n), 32'(exp_dmgo));
        chk("model_hold", 32'(cpu_hold), 32'(ph != 0));
        chk("model_idx", 32'(gnt_idx), 32'(midx));
        chk("model_tout", 32'(gnt_tout), 32'(mtout));
    end

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        logic ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dmgo_n != 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_seen", 32'(ok), 32'd1);
    endtask

    int low_cnt;
    logic [2:0] exp_seq [4];

    initial begin
`ifdef CONFIG_QBUS_DMA_RR_EN
        exp_seq = '{3'd0, 3'd3, 3'd0, 3'd3};
`else
        exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        rst_n = 1'b0; dmr_n = 4'hF; sack_n = 1'b1; sync_n = 1'b1; rply_n = 1'b1;
        edge_n(3);
        chk("rst_dmgo", 32'(dmgo_n), 32'hF);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_tout", 32'(gnt_tout), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Device 2, idle bus: latency 3 to hold, 4 to grant.
        dmr_n = 4'b1011;
        edge_n(3);
        chk("t1_hold", 32'(cpu_hold), 32'd1);
        chk("t1_dmgo_pre", 32'(dmgo_n), 32'hF);
        edge_n(1);
        chk("t1_dmgo", 32'(dmgo_n), 32'b1011);
        chk("t1_idx", 32'(gnt_idx), 32'd2);
        @(negedge clk) begin sack_n = 1'b0; dmr_n = 4'hF; end
        edge_n(2);
        chk("t1_dmgo_sack2", 32'(dmgo_n), 32'b1011);
        edge_n(1);
        chk("t1_dmgo_master", 32'(dmgo_n), 32'hF);
        repeat (5) @(negedge clk);
        sack_n = 1'b1;
        edge_n(3);
        chk("t1_hold_rel", 32'(cpu_hold), 32'd1);
        edge_n(1);
        chk("t1_hold_idle", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clk);

        // Bus cycle in progress delays the grant.
        sync_n = 1'b0; dmr_n = 4'b1110;
        repeat (10) @(negedge clk);
        chk("t2_hold", 32'(cpu_hold), 32'd1);
        chk("t2_dmgo_wait", 32'(dmgo_n), 32'hF);
        sync_n = 1'b1;
        edge_n(1);
        chk("t2_dmgo", 32'(dmgo_n), 32'b1110);
        @(negedge clk) begin sack_n = 1'b0; dmr_n = 4'hF; end
        repeat (5) @(negedge clk);
        sack_n = 1'b1;
        repeat (8) @(negedge clk);

        // Device 1 never acknowledges: timeout, then re-arbitration, then withdrawal.
        dmr_n = 4'b1101;
        wait_grant();
        low_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            edge_n(1);
            if (dmgo_n[1] == 1'b0) low_cnt++;
            else break;
        end
        chk("t3_low_cycles", 32'(low_cnt), 32'(GNT_TO));
        chk("t3_tout", 32'(gnt_tout), 32'd1);
        edge_n(1);
        chk("t3_tout_clr", 32'(gnt_tout), 32'd0);
        chk("t3_idle", 32'(cpu_hold), 32'd0);
        wait_grant();
        chk("t3_regrant", 32'(dmgo_n), 32'b1101);
        @(negedge clk) dmr_n = 4'hF;
        edge_n(2);
        chk("t6_dmgo_still", 32'(dmgo_n), 32'b1101);
        edge_n(1);
        chk("t6_dmgo_rel", 32'(dmgo_n), 32'hF);
        chk("t6_hold_rel", 32'(cpu_hold), 32'd1);
        chk("t6_tout", 32'(gnt_tout), 32'd0);
        edge_n(1);
        chk("t6_hold_idle", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clk);

        // Reset asserted while a device is master.
        dmr_n = 4'b1011;
        wait_grant();
        @(negedge clk) sack_n = 1'b0;
        edge_n(3);
        chk("t5_master_dmgo", 32'(dmgo_n), 32'hF);
        chk("t5_master_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk) begin rst_n = 1'b0; sack_n = 1'b1; end
        #1;
        chk("t5_rst_dmgo", 32'(dmgo_n), 32'hF);
        chk("t5_rst_hold", 32'(cpu_hold), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        edge_n(3);
        chk("t5_hold", 32'(cpu_hold), 32'd1);
        chk("t5_dmgo_pre", 32'(dmgo_n), 32'hF);
        edge_n(1);
        chk("t5_dmgo", 32'(dmgo_n), 32'b1011);
        @(negedge clk) begin sack_n = 1'b0; dmr_n = 4'hF; end
        repeat (5) @(negedge clk);
        sack_n = 1'b1;
        repeat (8) @(negedge clk);

        // Devices 0 and 3 request continuously; start from a cleared pointer.
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        dmr_n = 4'b0110;
        for (int t = 0; t < 4; t++) begin
            wait_grant();
            chk("t4_seq", 32'(gnt_idx), 32'(exp_seq[t]));
            @(negedge clk) sack_n = 1'b0;
            repeat (5) @(negedge clk);
            sack_n = 1'b1;
        end
        dmr_n = 4'hF;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
